// File: rtl/demux_register.sv
// Registered 1-to-2 demultiplexer feeding two independent FWFT FIFOs with drop-on-full.
// Optional dropped-write counter on ovf_cnt is enabled by defining DEMUX_OVF_CNT_EN.
module demux_register #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] d_in,
  input  logic             rd1,
  input  logic             rd2,
  output logic [WIDTH-1:0] d_out1,
  output logic [WIDTH-1:0] d_out2,
  output logic             vld1,
  output logic             vld2,
  output logic             full1,
  output logic             full2,
  output logic             ovf
`ifdef DEMUX_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       state [2];
  logic [1:0]       wr_req;
  logic [1:0]       rd_in;
  logic [1:0]       do_wr;
  logic [1:0]       do_rd;
  logic             drop;
  logic             ovf_q;
  logic             ovf_d;

  // Each channel's state is decoded straight from its occupancy count.
  always_comb begin
    wr_req = {en & sel, en & ~sel};
    rd_in  = {rd2, rd1};
    do_wr  = '0;
    do_rd  = '0;
    mem_d  = mem_q;
    for (int i = 0; i < 2; i++) begin
      state[i]    = ST_PARTIAL;
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (cnt_q[i] == '0)
        state[i] = ST_EMPTY;
      else if (cnt_q[i] == CNT_FULL)
        state[i] = ST_FULL;

      do_rd[i] = rd_in[i] && (state[i] != ST_EMPTY);
      do_wr[i] = wr_req[i] && ((state[i] != ST_FULL) || rd_in[i]);

      if (do_wr[i]) begin
        mem_d[i][wr_ptr_q[i]] = d_in;
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end
      if (do_rd[i])
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);

      case ({do_wr[i], do_rd[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    drop  = |(wr_req & ~do_wr);
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // Storage is deliberately unreset; empty channels force their output to zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign vld1   = (state[0] != ST_EMPTY);
  assign vld2   = (state[1] != ST_EMPTY);
  assign full1  = (state[0] == ST_FULL);
  assign full2  = (state[1] == ST_FULL);
  assign d_out1 = vld1 ? mem_q[0][rd_ptr_q[0]] : '0;
  assign d_out2 = vld2 ? mem_q[1][rd_ptr_q[1]] : '0;
  assign ovf    = ovf_q;

`ifdef DEMUX_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;
  logic [7:0] ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF))
      ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_cnt_q <= 8'd0;
    else
      ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
